// File: rtl/seg_display_driver.sv
// Four-digit multiplexed seven-segment driver. Digits are captured once per frame
// so a display frame never mixes old and new values, and the pair being adjusted blinks.
module seg_display_driver #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] m10,
   input  logic [3:0] m1,
   input  logic [2:0] s10,
   input  logic [3:0] s1,
   input  logic       adj,
   input  logic       sel,
   output logic [6:0] seg,
   output logic       dp,
   output logic [3:0] an
);

   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] scan_cnt;
   logic [1:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic [2:0]    sh_m10;
   logic [3:0]    sh_m1;
   logic [2:0]    sh_s10;
   logic [3:0]    sh_s1;

   logic          scan_wrap;
   logic          blink_wrap;
   logic          blank;
   logic [3:0]    digit;
   logic [6:0]    seg_next;

   assign scan_wrap  = (scan_cnt == SCAN_LAST);
   assign blink_wrap = (blink_cnt == BLINK_LAST);
   // Seconds pair sits on idx 0/1, minutes pair on idx 2/3.
   assign blank = adj && blink_ph && (sel ? (idx <= 2'd1) : (idx >= 2'd2));

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      digit = sh_s1;
      case (idx)
         2'd0:    digit = sh_s1;
         2'd1:    digit = {1'b0, sh_s10};
         2'd2:    digit = sh_m1;
         default: digit = {1'b0, sh_m10};
      endcase
   end

   always_comb begin
      seg_next = 7'b0111111;
      case (digit)
         4'd0:    seg_next = 7'b1000000;
         4'd1:    seg_next = 7'b1111001;
         4'd2:    seg_next = 7'b0100100;
         4'd3:    seg_next = 7'b0110000;
         4'd4:    seg_next = 7'b0011001;
         4'd5:    seg_next = 7'b0010010;
         4'd6:    seg_next = 7'b0000010;
         4'd7:    seg_next = 7'b1111000;
         4'd8:    seg_next = 7'b0000000;
         4'd9:    seg_next = 7'b0010000;
         default: seg_next = 7'b0111111;
      endcase
   end

   // NOTE: state uses non-blocking assignments so every register sees pre-edge values,
   // which is what lets a scan wrap and a blink wrap on the same edge both use old blink_ph.
   always_ff @(posedge clk) begin
      if (!rst) begin
         scan_cnt  <= '0;
         idx       <= 2'd0;
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
         sh_m10    <= 3'd0;
         sh_m1     <= 4'd0;
         sh_s10    <= 3'd0;
         sh_s1     <= 4'd0;
         an        <= 4'b1111;
         seg       <= 7'b1111111;
         dp        <= 1'b1;
      end else begin
         scan_cnt <= scan_wrap ? '0 : scan_cnt + 1'b1;
         if (scan_wrap) idx <= idx + 2'd1;
         if (scan_wrap && idx == 2'd3) begin
            sh_m10 <= m10;
            sh_m1  <= m1;
            sh_s10 <= s10;
            sh_s1  <= s1;
         end
         blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
         if (blink_wrap) blink_ph <= ~blink_ph;
         an  <= blank ? 4'b1111 : ~(4'b0001 << idx);
         seg <= seg_next;
         dp  <= !(idx == 2'd2 && !blank);
      end
   end

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: the stimulus side predicts each edge's
// outputs from slot/phase arithmetic and queues them; a monitor compares on negedges.
module tb_seg_display_driver;

   localparam int SD = 4;
   // A blink period of 12 against a 16-cycle frame lets the blank window visit every slot.
   localparam int BD = 6;
   localparam int FRAME = 4 * SD;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] m10;
   logic [3:0] m1;
   logic [2:0] s10;
   logic [3:0] s1;
   logic       adj;
   logic       sel;
   logic [6:0] seg;
   logic       dp;
   logic [3:0] an;

   always #5 clk = ~clk;

   seg_display_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
      .clk(clk), .rst(rst), .m10(m10), .m1(m1), .s10(s10), .s1(s1),
      .adj(adj), .sel(sel), .seg(seg), .dp(dp), .an(an)
   );

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;
   int   t     = 0;
   int   sh[4] = '{0, 0, 0, 0};

   function automatic logic [6:0] dec(input int d);
      case (d)
         0:       return 7'b1000000;
         1:       return 7'b1111001;
         2:       return 7'b0100100;
         3:       return 7'b0110000;
         4:       return 7'b0011001;
         5:       return 7'b0010010;
         6:       return 7'b0000010;
         7:       return 7'b1111000;
         8:       return 7'b0000000;
         9:       return 7'b0010000;
         default: return 7'b0111111;
      endcase
   endfunction

   function automatic logic [3:0] an_of(input int i);
      case (i)
         0:       return 4'b1110;
         1:       return 4'b1101;
         2:       return 4'b1011;
         default: return 4'b0111;
      endcase
   endfunction

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at t=%0d: got %b expected %b", name, $time, act, req);
      end
   endtask

   // Predict the next edge from the inputs now applied, queue it, advance one cycle.
   task automatic cyc();
      exp_t e;
      int   slot;
      int   ph;
      logic blank;
      if (!rst) begin
         e.an  = 4'b1111;
         e.seg = 7'b1111111;
         e.dp  = 1'b1;
         t     = 0;
         sh    = '{0, 0, 0, 0};
      end else begin
         slot  = (t / SD) % 4;
         ph    = (t / BD) % 2;
         blank = adj && (ph == 1) && (sel ? (slot <= 1) : (slot >= 2));
         e.an  = blank ? 4'b1111 : an_of(slot);
         e.seg = dec(sh[slot]);
         e.dp  = (slot == 2 && !blank) ? 1'b0 : 1'b1;
         if (t % FRAME == FRAME - 1) sh = '{int'(s1), int'(s10), int'(m1), int'(m10)};
         t++;
      end
      sb_q.push_back(e);
      @(negedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc();
   endtask

   task automatic run_to(input int pos);
      for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) cyc();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("an", {3'b000, an}, {3'b000, e.an});
            check("seg", seg, e.seg);
            check("dp", {6'b0, dp}, {6'b0, e.dp});
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      rst = 1'b0; m10 = 3'd1; m1 = 4'd2; s10 = 3'd3; s1 = 4'd4; adj = 1'b0; sel = 1'b0;
      @(negedge clk);
      #1;
      run(3);

      // First frame shows zeros, second shows 1 2 3 4 with the separator on the m1 slot.
      rst = 1'b1;
      run(2 * FRAME);

      // Mid-frame change of s1 must wait for the next frame boundary.
      run_to(5);
      s1 = 4'd7;
      run(2 * FRAME + 4);

      // Out-of-range digit shows a dash.
      m1 = 4'd12;
      run(2 * FRAME);
      m1 = 4'd5;
      m10 = 3'd7;
      s10 = 3'd6;
      run(2 * FRAME);

      // Blink: seconds pair, minutes pair, then adjust off.
      adj = 1'b1; sel = 1'b1;
      run(48);
      sel = 1'b0;
      run(48);
      adj = 1'b0;
      run(48);

      // Reset while idx = 2 and scan_cnt = 1, then restart.
      run_to(9);
      rst = 1'b0;
      run(2);
      rst = 1'b1;
      run(FRAME + 4);

      for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clk);
      #1;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
